pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
Program-counter and fetch-redirect stage that sits directly downstream of the branch decider.
- Holds the architectural fetch PC and advances it by 4 each cycle.
- When the EX-stage instruction is a taken branch (branch_taken from the decider) or a jump (JAL/JALR), it computes the target, redirects fetch and squashes the wrong-path instructions in IF/ID and ID/EX.
- A misaligned target raises a trap and vectors to TRAP_VEC.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, fetch address after reset
TRAP_VEC, 32'h0000_0100, fetch address on misaligned-target trap
FLUSH_SLOTS, 2, cycles after a redirect during which EX results are ignored (1..3)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard hold; freezes PC when no redirect
ex_valid  in  1  EX stage holds a real instruction
branch_taken  in  1  from branch decider (conditional branch resolved taken)
ex_jump  in  1  EX instruction is JAL or JALR (unconditional)
ex_jalr  in  1  target base is rs1 rather than ex_pc
ex_pc  in  XLEN  PC of EX instruction
ex_rs1  in  XLEN  rs1 operand value
ex_imm  in  XLEN  sign-extended immediate
pc  out  XLEN  current fetch address
if_valid  out  1  fetch address is valid this cycle
flush_ifid  out  1  squash IF/ID register (combinational)
flush_idex  out  1  squash ID/EX register (combinational)
redirect  out  1  target taken this cycle (combinational)
link_pc  out  XLEN  ex_pc+4 for rd write on jumps (combinational)
trap  out  1  one-cycle misaligned-target pulse (registered)
trap_epc  out  XLEN  ex_pc of faulting instruction, held until next trap

Behaviour:
- Reset values (cycle after reset sampled high):
  - pc=RESET_PC, if_valid=0, trap=0, trap_epc=0
  - state=BOOT, squash_cnt=0
- reset has priority over every other input.
- States:
  - BOOT: lasts exactly one cycle, if_valid=0, pc held; then RUN.
  - RUN: if_valid=1.
  - SQUASH: if_valid=1, squash_cnt>0.
- ex_eff = ex_valid & (state==RUN).
  - In BOOT and SQUASH, all EX inputs are ignored: no redirect and no trap.
- take = ex_eff & (branch_taken | ex_jump).
- Target and alignment:
  - tgt = ex_jalr ? ((ex_rs1+ex_imm) & ~1) : (ex_pc+ex_imm), with mod-2^XLEN wrap and no overflow flag.
  - misalign = take & tgt[1].
- Redirect path: redirect = take & ~misalign.
  - Same cycle: flush_ifid=flush_idex=redirect|misalign.
  - Next edge: pc<=tgt, state<=SQUASH, squash_cnt<=FLUSH_SLOTS.
- Trap path (misalign):
  - Next edge: pc<=TRAP_VEC, trap<=1 for exactly one cycle, trap_epc<=ex_pc, state<=SQUASH, squash_cnt<=FLUSH_SLOTS.
  - No redirect to tgt.
- Redirect and trap override stall. Stall never delays a redirect.
- Otherwise:
  - stall=1: pc held.
  - stall=0: pc<=pc+4 (wraps at 2^XLEN).
- SQUASH:
  - squash_cnt decrements on each cycle with stall=0; held while stalled.
  - On reaching 0 the next state is RUN.
  - pc advances or stalls as in RUN.
- link_pc = ex_pc+4 always; it is the consumer's job to qualify it with ex_jump.
- branch_taken and ex_jump both high: treated as one take, no double action.
- reset mid-SQUASH or during a trap pulse: everything returns to reset values next cycle; the trap pulse is cut.
- No latency beyond one cycle: the redirected target is on pc in the cycle after EX resolves.

Test Plan:
1. Reset then idle:
   - Stimulus: reset 1 cycle, release, stall=0, ex_valid=0.
   - Required: pc=0 and if_valid=0 for one cycle, then pc 0,4,8,12 with if_valid=1.
2. Taken branch:
   - Stimulus: in RUN with pc=0x20, ex_valid=1, branch_taken=1, ex_pc=0x18, ex_imm=0x40.
   - Required: redirect=flush_ifid=flush_idex=1 that cycle; next pc=0x58.
   - Required: ex_valid=1 with branch_taken=1 during the next 2 unstalled cycles causes no redirect; then pc continues 0x5C, 0x60.
3. JALR with bit0 cleared:
   - Stimulus: ex_jump=ex_jalr=1, ex_rs1=0x1001, ex_imm=0x0FF.
   - Required: tgt=0x1100, link_pc=ex_pc+4, no trap.
4. Misaligned target:
   - Stimulus: ex_jump=1, ex_jalr=0, ex_pc=0x30, ex_imm=0x6.
   - Required: flushes high that cycle; next cycle pc=0x100, trap=1 for one cycle, trap_epc=0x30; redirect=0.
5. Stall interplay:
   - Stimulus: stall=1 for 3 cycles with pc=0x40.
   - Required: pc stays 0x40.
   - Stimulus: during a stall, a taken branch with tgt=0x80.
   - Required: pc=0x80 next cycle regardless of stall; squash_cnt holds while stall stays high.
6. Reset mid-SQUASH:
   - Stimulus: assert reset the cycle after a redirect.
   - Required: pc=RESET_PC, if_valid=0, trap=0, state=BOOT next cycle.

Source files
------------

// File: rtl/pc_next_unit.sv
// Purpose: fetch PC register with branch/jump redirect, wrong-path squash and misaligned-target trap.
// Latency: redirect, flushes and link_pc are combinational; the new pc and the trap pulse appear one cycle later.
// Backpressure: stall freezes pc and the squash count; a redirect or trap always wins over stall.
module pc_next_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100),
   parameter int              FLUSH_SLOTS = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            ex_valid,
   input  logic            branch_taken,
   input  logic            ex_jump,
   input  logic            ex_jalr,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_imm,
   output logic [XLEN-1:0] pc,
   output logic            if_valid,
   output logic            flush_ifid,
   output logic            flush_idex,
   output logic            redirect,
   output logic [XLEN-1:0] link_pc,
   output logic            trap,
   output logic [XLEN-1:0] trap_epc
);

   typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

   // Squash window length; a 2-bit counter covers the legal range 1..3.
   localparam logic [1:0] SLOTS = 2'(FLUSH_SLOTS);

   state_t          state, state_nxt;
   logic [1:0]      squash_cnt, squash_cnt_nxt;
   logic [XLEN-1:0] pc_nxt, trap_epc_nxt;
   logic            trap_nxt;

   logic            ex_eff, take, misalign;
   logic [XLEN-1:0] jalr_sum, tgt;

   // EX is only trusted in RUN; the squash window hides wrong-path results.
   assign ex_eff   = ex_valid & (state == RUN);
   assign take     = ex_eff & (branch_taken | ex_jump);
   assign jalr_sum = ex_rs1 + ex_imm;
   assign tgt      = ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
   assign misalign = take & tgt[1];

   assign redirect   = take & ~misalign;
   assign flush_ifid = redirect | misalign;
   assign flush_idex = redirect | misalign;
   assign link_pc    = ex_pc + XLEN'(4);
   assign if_valid   = (state != BOOT);

   // Next-state, next-pc and trap decisions; trap beats redirect beats stall/advance.
   always_comb begin
      state_nxt      = state;
      squash_cnt_nxt = squash_cnt;
      pc_nxt         = pc;
      trap_nxt       = 1'b0;
      trap_epc_nxt   = trap_epc;
      if (misalign) begin
         pc_nxt         = TRAP_VEC;
         trap_nxt       = 1'b1;
         trap_epc_nxt   = ex_pc;
         state_nxt      = SQUASH;
         squash_cnt_nxt = SLOTS;
      end else if (redirect) begin
         pc_nxt         = tgt;
         state_nxt      = SQUASH;
         squash_cnt_nxt = SLOTS;
      end else begin
         case (state)
            BOOT: begin
               state_nxt = RUN;
            end
            RUN: begin
               if (!stall) pc_nxt = pc + XLEN'(4);
            end
            SQUASH: begin
               if (!stall) begin
                  pc_nxt         = pc + XLEN'(4);
                  squash_cnt_nxt = squash_cnt - 2'd1;
                  if (squash_cnt <= 2'd1) begin
                     squash_cnt_nxt = 2'd0;
                     state_nxt      = RUN;
                  end
               end
            end
            default: begin
               state_nxt      = BOOT;
               squash_cnt_nxt = 2'd0;
            end
         endcase
      end
   end

   // State, pc and trap registers; reset dominates and cuts any trap pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= BOOT;
         squash_cnt <= 2'd0;
         pc         <= RESET_PC;
         trap       <= 1'b0;
         trap_epc   <= '0;
      end else begin
         state      <= state_nxt;
         squash_cnt <= squash_cnt_nxt;
         pc         <= pc_nxt;
         trap       <= trap_nxt;
         trap_epc   <= trap_epc_nxt;
      end
   end

endmodule
